// File: rtl/ro_puf_sig_engine.sv
// RO-PUF signature engine: steps a challenge index over N_PAIRS ring-oscillator
// pairs and counts the rising edges of each selected pair over a fixed window.
// Each measurement is repeated N_VOTE times and the response bit is decided by
// majority vote. Low-margin bits are flagged, and the signature is returned in
// parallel under a start/busy/done handshake.
module ro_puf_sig_engine #(
   parameter int N_PAIRS    = 128,
   parameter int CW         = 7,
   parameter int CNT_W      = 32,
   parameter int WIN_CYC    = 1024,
   parameter int SETTLE_CYC = 4,
   parameter int N_VOTE     = 1,
   parameter int THRESH     = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_PAIRS-1:0] ro_a,
   input  logic [N_PAIRS-1:0] ro_b,
   output logic               ro_en,
   output logic               busy,
   output logic               done,
   output logic [CW-1:0]      challenge,
   output logic               bit_valid,
   output logic               bit_out,
   output logic [N_PAIRS-1:0] sig,
   output logic [N_PAIRS-1:0] unstable
);

   localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int VW      = $clog2(N_VOTE + 1);

   localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYC - 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [VW-1:0]    VOTE_HALF   = VW'(N_VOTE / 2);
   localparam logic [VW-1:0]    VOTE_ALL    = VW'(N_VOTE);
   localparam logic [VW-1:0]    VOTE_LAST   = VW'(N_VOTE - 1);
   localparam logic [CNT_W:0]   THRESH_V    = (CNT_W + 1)'(THRESH);
   localparam logic [CW-1:0]    LAST_CH     = CW'(N_PAIRS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_COUNT, S_SETTLE, S_COMPARE, S_DONE
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] tmr;
   logic [VW-1:0]    rep;
   logic [VW-1:0]    ones;
   logic             margin;
   logic             gate;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   // The selected RO outputs are the counter clocks. The counters are cleared
   // asynchronously from the clk domain, so a clear needs no RO edge to land.
   logic ro_a_sel;
   logic ro_b_sel;
   logic cnt_rst_n;

   assign ro_a_sel  = ro_a[challenge];
   assign ro_b_sel  = ro_b[challenge];
   assign cnt_rst_n = rst & ~cnt_clr;

   logic           meas_bit;
   logic [CNT_W:0] diff;
   logic           margin_nxt;
   logic [VW-1:0]  ones_nxt;
   logic           voted;
   logic           unst_nxt;

   // Compare and vote datapath; the counts are frozen while this is used.
   always_comb begin
      // NOTE: every output here is assigned on every path, so no latch is inferred.
      meas_bit   = cnt_a > cnt_b;
      diff       = meas_bit ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                            : ({1'b0, cnt_b} - {1'b0, cnt_a});
      margin_nxt = margin | (diff <= THRESH_V);
      ones_nxt   = ones + VW'(meas_bit);
      voted      = ones_nxt > VOTE_HALF;
      unst_nxt   = margin_nxt | ((ones_nxt != '0) && (ones_nxt != VOTE_ALL));
   end

   // Edge counter A: clocked by the selected bank-A RO, saturating.
   always_ff @(posedge ro_a_sel or negedge cnt_rst_n) begin
      if (!cnt_rst_n)
         cnt_a <= '0;
      else if (gate && (cnt_a != '1))
         cnt_a <= cnt_a + 1'b1;
   end

   // Edge counter B: clocked by the selected bank-B RO, saturating.
   always_ff @(posedge ro_b_sel or negedge cnt_rst_n) begin
      if (!cnt_rst_n)
         cnt_b <= '0;
      else if (gate && (cnt_b != '1))
         cnt_b <= cnt_b + 1'b1;
   end

   // Control FSM with registered outputs and the signature registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: non-blocking assignments keep every register updating from the
         // same pre-edge values, whatever order these statements run in.
         state     <= S_IDLE;
         tmr       <= '0;
         rep       <= '0;
         ones      <= '0;
         margin    <= 1'b0;
         gate      <= 1'b0;
         cnt_clr   <= 1'b0;
         ro_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         challenge <= '0;
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         sig       <= '0;
         unstable  <= '0;
      end else begin
         bit_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sig       <= '0;
                  unstable  <= '0;
                  challenge <= '0;
                  rep       <= '0;
                  ones      <= '0;
                  busy      <= 1'b1;
                  ro_en     <= 1'b1;
                  cnt_clr   <= 1'b1;
                  state     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               cnt_clr <= 1'b0;
               margin  <= 1'b0;
               gate    <= 1'b1;
               tmr     <= WIN_LOAD;
               state   <= S_COUNT;
            end
            S_COUNT: begin
               if (tmr == '0) begin
                  gate  <= 1'b0;
                  tmr   <= SETTLE_LOAD;
                  state <= S_SETTLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_SETTLE: begin
               if (tmr == '0)
                  state <= S_COMPARE;
               else
                  tmr <= tmr - 1'b1;
            end
            S_COMPARE: begin
               if (rep != VOTE_LAST) begin
                  rep     <= rep + 1'b1;
                  ones    <= ones_nxt;
                  margin  <= margin_nxt;
                  cnt_clr <= 1'b1;
                  state   <= S_CLEAR;
               end else begin
                  sig[challenge]      <= voted;
                  unstable[challenge] <= unst_nxt;
                  bit_valid           <= 1'b1;
                  bit_out             <= voted;
                  ones                <= '0;
                  rep                 <= '0;
                  margin              <= 1'b0;
                  if (challenge == LAST_CH) begin
                     ro_en <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     challenge <= challenge + 1'b1;
                     cnt_clr   <= 1'b1;
                     state     <= S_CLEAR;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_puf_sig_engine.sv
// Bench for ro_puf_sig_engine. Three instances: a baseline engine, a 3-vote
// engine and a 3-bit-counter engine. RO inputs are synthetic periodic waves
// built on a half-cycle grid offset from the clock edges. Expected response
// bits go into a queue per instance when a run is started and are popped on
// each bit_valid pulse.
module tb_ro_puf_sig_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start_m = 1'b0, start_v = 1'b0, start_s = 1'b0;
   logic [3:0] ro_a = '0, ro_b = '0, ro_a_v = '0, ro_b_v = '0, ro_s = '0;
   logic swap = 1'b0;

   logic ro_en_m, busy_m, done_m, bit_valid_m, bit_out_m;
   logic ro_en_v, busy_v, done_v, bit_valid_v, bit_out_v;
   logic ro_en_s, busy_s, done_s, bit_valid_s, bit_out_s;
   logic [1:0] challenge_m, challenge_v, challenge_s;
   logic [3:0] sig_m, sig_v, sig_s, unstable_m, unstable_v, unstable_s;

   int n_checks = 0;
   int n_errors = 0;
   bit q_m[$];
   bit q_v[$];
   bit q_s[$];

   // Periods in clk cycles for bank A and bank B of each pair.
   int pa[4] = '{2, 4, 4, 2};
   int pb[4] = '{4, 2, 4, 8};

   always #5 clk = ~clk;

   ro_puf_sig_engine #(.N_PAIRS(4), .CW(2), .CNT_W(8), .WIN_CYC(16),
                       .SETTLE_CYC(2), .N_VOTE(1), .THRESH(1)) u_main (
      .clk(clk), .rst(rst), .start(start_m), .ro_a(ro_a), .ro_b(ro_b),
      .ro_en(ro_en_m), .busy(busy_m), .done(done_m), .challenge(challenge_m),
      .bit_valid(bit_valid_m), .bit_out(bit_out_m), .sig(sig_m), .unstable(unstable_m));

   ro_puf_sig_engine #(.N_PAIRS(4), .CW(2), .CNT_W(8), .WIN_CYC(16),
                       .SETTLE_CYC(2), .N_VOTE(3), .THRESH(1)) u_vote (
      .clk(clk), .rst(rst), .start(start_v), .ro_a(ro_a_v), .ro_b(ro_b_v),
      .ro_en(ro_en_v), .busy(busy_v), .done(done_v), .challenge(challenge_v),
      .bit_valid(bit_valid_v), .bit_out(bit_out_v), .sig(sig_v), .unstable(unstable_v));

   ro_puf_sig_engine #(.N_PAIRS(4), .CW(2), .CNT_W(3), .WIN_CYC(16),
                       .SETTLE_CYC(2), .N_VOTE(1), .THRESH(1)) u_sat (
      .clk(clk), .rst(rst), .start(start_s), .ro_a(ro_s), .ro_b(ro_s),
      .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .challenge(challenge_s),
      .bit_valid(bit_valid_s), .bit_out(bit_out_s), .sig(sig_s), .unstable(unstable_s));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic wave(input int h, input int p);
      return (h % (2 * p)) < p;
   endfunction

   // RO wave generator: one update per half clk cycle, 2 ns after time zero.
   initial begin
      int h;
      h = 0;
      #2;
      forever begin
         for (int i = 0; i < 4; i++) begin
            ro_a[i] = wave(h, pa[i]);
            ro_b[i] = wave(h, pb[i]);
         end
         ro_a_v = ro_a;
         ro_b_v = ro_b;
         if (swap) begin
            ro_a_v[0] = wave(h, pb[0]);
            ro_b_v[0] = wave(h, pa[0]);
         end
         ro_s = wave(h, 1) ? 4'hF : 4'h0;
         #5;
         h++;
      end
   end

   // Scoreboard pop for each instance on its bit_valid pulse.
   always @(negedge clk) begin
      if (bit_valid_m === 1'b1) begin
         if (q_m.size() == 0) check("m_sb_unexpected", 64'(q_m.size()), 1);
         else                 check("m_bit", bit_out_m, q_m.pop_front());
      end
      if (bit_valid_v === 1'b1) begin
         if (q_v.size() == 0) check("v_sb_unexpected", 64'(q_v.size()), 1);
         else                 check("v_bit", bit_out_v, q_v.pop_front());
      end
      if (bit_valid_s === 1'b1) begin
         if (q_s.size() == 0) check("s_sb_unexpected", 64'(q_s.size()), 1);
         else                 check("s_bit", bit_out_s, q_s.pop_front());
      end
   end

   task automatic set_start(input int d, input logic v);
      case (d)
         0:       start_m = v;
         1:       start_v = v;
         default: start_s = v;
      endcase
   endtask

   function automatic logic busy_of(input int d);
      case (d)
         0:       return busy_m;
         1:       return busy_v;
         default: return busy_s;
      endcase
   endfunction

   function automatic logic done_of(input int d);
      case (d)
         0:       return done_m;
         1:       return done_v;
         default: return done_s;
      endcase
   endfunction

   // One-cycle start pulse; returns at the first negedge with busy expected high.
   task automatic pulse_start(input int d, input string tag);
      @(negedge clk);
      set_start(d, 1'b1);
      @(negedge clk);
      set_start(d, 1'b0);
      check(tag, busy_of(d), 1);
   endtask

   // Counts clk cycles until done is seen, bounded past the expected value.
   task automatic measure_done(input int d, input int exp, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done_of(d) !== 1'b1 && n < exp + 20);
      check(tag, 64'(n), 64'(exp));
   endtask

   task automatic push_m(input bit [3:0] bits);
      for (int i = 0; i < 4; i++) q_m.push_back(bits[i]);
   endtask

   initial begin
      int n, k;
      logic [1:0] prev;
      bit mono;

      // Reset with random start levels.
      repeat (3) begin
         @(negedge clk);
         start_m = 1'($urandom);
         start_v = 1'($urandom);
         start_s = 1'($urandom);
      end
      check("rst_ctrl", {ro_en_m, busy_m, done_m, bit_valid_m}, 4'b0000);
      check("rst_sig", sig_m, 4'h0);
      check("rst_unstable", unstable_m, 4'h0);
      check("rst_challenge", challenge_m, 2'd0);
      check("rst_other", {ro_en_v, busy_v, ro_en_s, busy_s, sig_v, sig_s}, 12'h000);
      start_m = 1'b0;
      start_v = 1'b0;
      start_s = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Basic signature: bits 1,0,0,1; pair 2 has equal counts.
      push_m(4'b1001);
      pulse_start(0, "m_busy_rise");
      measure_done(0, 80, "m_latency");
      check("m_sig", sig_m, 4'b1001);
      check("m_unstable", unstable_m, 4'b0100);
      check("m_done_roen", ro_en_m, 0);
      @(negedge clk);
      check("m_sb_drain", 64'(q_m.size()), 0);
      check("m_idle_busy", busy_m, 0);

      // Handshake: start pulse mid-run is ignored; start held across DONE.
      push_m(4'b1001);
      pulse_start(0, "hs_busy_rise");
      n = 0;
      prev = 2'd0;
      mono = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (n == 30) start_m = 1'b1;
         if (n == 31) start_m = 1'b0;
         if (n == 75) begin
            start_m = 1'b1;
            push_m(4'b1001);
         end
         if (challenge_m < prev) mono = 1'b0;
         prev = challenge_m;
      end while (done_m !== 1'b1 && n < 100);
      check("hs_latency", 64'(n), 80);
      check("hs_chal_monotonic", mono, 1);
      check("hs_done_busy", busy_m, 1);
      check("hs_sig", sig_m, 4'b1001);
      @(negedge clk);
      check("hs_idle_gap", busy_m, 0);
      check("hs_sig_hold", sig_m, 4'b1001);
      @(negedge clk);
      check("hs_restart_busy", busy_m, 1);
      check("hs_restart_sig", sig_m, 4'h0);
      check("hs_restart_chal", challenge_m, 2'd0);
      start_m = 1'b0;

      // Reset mid-run during COUNT of challenge 2.
      k = 0;
      while (challenge_m != 2'd2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("mr_reach_ch2", challenge_m, 2'd2);
      repeat (5) @(negedge clk);
      check("mr_pre_ctrl", {ro_en_m, busy_m}, 2'b11);
      #1 rst = 1'b0;
      #1;
      check("mr_async_ctrl", {ro_en_m, busy_m}, 2'b00);
      check("mr_async_sig", sig_m, 4'h0);
      check("mr_async_chal", challenge_m, 2'd0);
      q_m.delete();
      @(negedge clk);
      rst = 1'b1;
      push_m(4'b1001);
      pulse_start(0, "mr_busy_rise");
      measure_done(0, 80, "mr_latency");
      check("mr_sig", sig_m, 4'b1001);
      check("mr_unstable", unstable_m, 4'b0100);

      // Voting: pair 0 swaps which bank is faster on the middle repetition.
      for (int i = 0; i < 4; i++) q_v.push_back(i == 0 || i == 3);
      pulse_start(1, "v_busy_rise");
      repeat (20) @(negedge clk);
      swap = 1'b1;
      repeat (20) @(negedge clk);
      swap = 1'b0;
      // 40 of the 240 cycles have already elapsed here.
      measure_done(1, 200, "v_latency");
      check("v_sig", sig_v, 4'b1001);
      check("v_unstable", unstable_v, 4'b0101);

      // Saturation: both banks at one edge per cycle into 3-bit counters.
      for (int i = 0; i < 4; i++) q_s.push_back(1'b0);
      pulse_start(2, "s_busy_rise");
      measure_done(2, 80, "s_latency");
      check("s_sig", sig_s, 4'h0);
      check("s_unstable", unstable_s, 4'b1111);

      @(negedge clk);
      check("end_sb_drain", 64'(q_m.size() + q_v.size() + q_s.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
